// File: rtl/data_memory.sv
// Word-organised data memory for the MIPS MEM stage.
// Combinational read, synchronous write, asynchronous active-low clear of the
// whole array. Storage is built from flops so that the clear can be
// asynchronous. Addresses are byte addresses, and the low two bits are ignored.
// Any address that falls outside the array reads as zero and is never written.
module data_memory #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [31:0]      a,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wordIdx;
    logic             inRange;

    // Word index comes from the address bits just above the byte offset.
    // The range check shifts out the index and offset bits, and requires every
    // remaining upper bit to be zero, so oversized addresses never alias back
    // into the array.
    assign wordIdx = a[AW+1:2];
    assign inRange = ((a >> (AW + 2)) == 32'd0);

    // Clear every word on reset; otherwise load one word per enabled in-range edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && inRange) begin
            mem[wordIdx] <= wd;
        end
    end

    // Zero-latency read with no write-through bypass; out-of-range reads return zero
    always_comb begin
        rd = '0;
        if (inRange) begin
            rd = mem[wordIdx];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory.
// The reference model is a plain array of words. It is indexed by byte
// address divided by four, and addresses beyond the array read as zero.
module tb_data_memory;

    localparam int DEPTH = 64;
    localparam int BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [DEPTH];

    data_memory #(.DEPTH(DEPTH), .WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    // Reference read: in range when the byte address is below the array size
    function automatic logic [31:0] ref_read(input logic [31:0] addr);
        if (addr < 32'(BYTES)) return model[addr / 4];
        return 32'h0;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endfunction

    // Drive one write cycle and mirror it into the model
    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        we = 1'b1;
        a  = addr;
        wd = data;
        @(posedge clk);
        #1;
        we = 1'b0;
        if (rst_n && addr < 32'(BYTES)) model[addr / 4] = data;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [3];
        addrs = '{32'd0, 32'd4, 32'd252};
        rst_n = 1'b0;
        we    = 1'b0;
        a     = 32'h0;
        wd    = 32'h0;
        #12;
        rst_n = 1'b1;
        model_clear();
        foreach (addrs[i]) begin
            a = addrs[i];
            #1;
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_read a=%h rd=%h expected=%h", a, rd, 32'h0);
            end
        end
    endtask

    task automatic test_write();
        logic [31:0] addrs [3];
        logic [31:0] exp   [3];
        addrs = '{32'd4, 32'd0, 32'd8};
        exp   = '{32'hdeadbeef, 32'h0, 32'h0};
        write_word(32'd4, 32'hdeadbeef);
        foreach (addrs[i]) begin
            a = addrs[i];
            #1;
            checks++;
            if (rd !== exp[i]) begin
                errors++;
                $display("[TB] FAIL basic_write a=%h rd=%h expected=%h", a, rd, exp[i]);
            end
        end
    endtask

    task automatic test_alias();
        for (int off = 5; off <= 7; off++) begin
            a = 32'(off);
            #1;
            checks++;
            if (rd !== 32'hdeadbeef) begin
                errors++;
                $display("[TB] FAIL alias_read a=%h rd=%h expected=%h", a, rd, 32'hdeadbeef);
            end
        end
        write_word(32'd6, 32'h12345678);
        a = 32'd4;
        #1;
        checks++;
        if (rd !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL alias_write a=%h rd=%h expected=%h", a, rd, 32'h12345678);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] addrs [4];
        addrs = '{32'd256, 32'd0, 32'd4, 32'h8000_0000};
        write_word(32'd256, 32'hcafef00d);
        write_word(32'h8000_0004, 32'h0badf00d);
        foreach (addrs[i]) begin
            a = addrs[i];
            #1;
            checks++;
            if (rd !== ref_read(addrs[i])) begin
                errors++;
                $display("[TB] FAIL out_of_range a=%h rd=%h expected=%h", a, rd, ref_read(addrs[i]));
            end
        end
    endtask

    task automatic test_write_control();
        @(negedge clk);
        we = 1'b0;
        a  = 32'd8;
        wd = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL we_low a=%h rd=%h expected=%h", a, rd, 32'h0);
        end
        @(negedge clk);
        we = 1'b1;
        wd = 32'h1;
        @(negedge clk);
        wd = 32'h2;
        @(posedge clk);
        #1;
        we = 1'b0;
        model[2] = 32'h2;
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("[TB] FAIL back_to_back a=%h rd=%h expected=%h", a, rd, 32'h2);
        end
    endtask

    task automatic test_read_during_write();
        logic [31:0] oldVal;
        logic [31:0] newVal;
        oldVal = model[3];
        newVal = $urandom;
        @(negedge clk);
        we = 1'b1;
        a  = 32'd12;
        wd = newVal;
        #1;
        checks++;
        if (rd !== oldVal) begin
            errors++;
            $display("[TB] FAIL rdw_before a=%h rd=%h expected=%h", a, rd, oldVal);
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        model[3] = newVal;
        checks++;
        if (rd !== newVal) begin
            errors++;
            $display("[TB] FAIL rdw_after a=%h rd=%h expected=%h", a, rd, newVal);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int unsigned sel;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)      addr = 32'($urandom_range(0, BYTES - 1));
            else if (sel < 9) addr = 32'(BYTES) + 32'($urandom_range(0, 255));
            else              addr = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                write_word(addr, $urandom);
            end else begin
                a = addr;
                #1;
                checks++;
                if (rd !== ref_read(addr)) begin
                    errors++;
                    $display("[TB] FAIL random_read a=%h rd=%h expected=%h", a, rd, ref_read(addr));
                end
            end
        end
        for (int w = 0; w < DEPTH; w++) begin
            a = 32'(w * 4 + int'($urandom_range(0, 3)));
            #1;
            checks++;
            if (rd !== model[w]) begin
                errors++;
                $display("[TB] FAIL sweep_read a=%h rd=%h expected=%h", a, rd, model[w]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        for (int w = 0; w < 4; w++) write_word(32'(w * 4), 32'hA5A5_0000 | 32'(w + 1));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_clear();
        for (int w = 0; w < 4; w++) begin
            a = 32'(w * 4);
            #1;
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_async a=%h rd=%h expected=%h", a, rd, 32'h0);
            end
        end
        @(negedge clk);
        we = 1'b1;
        a  = 32'd0;
        wd = 32'hffffffff;
        @(posedge clk);
        #1;
        we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int w = 0; w < 4; w++) begin
            a = 32'(w * 4);
            #1;
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_blocks_write a=%h rd=%h expected=%h", a, rd, 32'h0);
            end
        end
        write_word(32'd0, 32'h600d_cafe);
        a = 32'd0;
        #1;
        checks++;
        if (rd !== 32'h600d_cafe) begin
            errors++;
            $display("[TB] FAIL first_write_after_reset a=%h rd=%h expected=%h", a, rd, 32'h600d_cafe);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        $display("[TB] data_memory bench start");
        test_reset();
        test_write();
        test_alias();
        test_out_of_range();
        test_write_control();
        test_read_during_write();
        test_random();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL timeout a=%h rd=%h expected=finish", a, rd);
        $fatal(1, "[TB] timeout");
    end

endmodule
